// File: rtl/spi_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_pkg
// Brief    : Shared state encoding and phase-length helper for the SPI SCK generator
// Revision : 1.0
// ============================================================================
package spi_clk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_IDLE_PH = 2'd1;
    localparam state_t c_ST_ACT_PH  = 2'd2;
    localparam state_t c_ST_HOLD    = 2'd3;

    localparam int c_MIN_DIV = 2;

    typedef struct packed {
        logic [31:0] la;
        logic [31:0] li;
    } phase_len_t;

    // Odd ratios put the spare cycle on the idle level.
    function automatic phase_len_t calc_phase(input logic [31:0] div);
        logic [31:0] d;
        phase_len_t  p;
        d    = (div < 32'(c_MIN_DIV)) ? 32'(c_MIN_DIV) : div;
        p.la = d >> 1;
        p.li = d - p.la;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : spi_phase_cnt
// Brief    : Loadable terminal-count counter timing one SCK phase
// Revision : 1.0
// ============================================================================
module spi_phase_cnt #(
    parameter int DIV_W = 15
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] limit,
    output logic             tc
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign tc = en && (r_cnt == limit);

endmodule
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sck_gen
// Brief    : Programmable-ratio SCK burst generator with edge strobes
// Revision : 1.0
// ============================================================================
module spi_sck_gen #(
    parameter int DIV_W = 15,
    parameter int CNT_W = 6
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic [CNT_W-1:0] nbits,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             lead_stb,
    output logic             trail_stb
);

    import spi_clk_pkg::*;

    localparam logic [DIV_W-1:0] c_DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic             r_cpol_l;
    logic [CNT_W-1:0] r_nbits_l;
    logic [CNT_W-1:0] r_bitcnt;
    logic [DIV_W-1:0] r_la_m1;
    logic [DIV_W-1:0] r_li_m1;
    logic             r_busy;
    logic             r_done;
    logic             r_sck;
    logic             r_lead;
    logic             r_trail;

    phase_len_t       w_ph;
    logic [DIV_W-1:0] w_la;
    logic [DIV_W-1:0] w_li;
    logic [DIV_W-1:0] w_limit;
    logic             w_en;
    logic             w_load;
    logic             w_tc;

    assign w_ph    = calc_phase(32'(div));
    assign w_la    = DIV_W'(w_ph.la);
    assign w_li    = DIV_W'(w_ph.li);
    assign w_limit = (r_state == c_ST_ACT_PH) ? r_la_m1 : r_li_m1;
    assign w_en    = (r_state != c_ST_IDLE);
    // Restart the phase count on every phase boundary and while idle.
    assign w_load  = (r_state == c_ST_IDLE) || w_tc;

    spi_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase_cnt (
        .clkin (clkin),
        .reset (reset),
        .load  (w_load),
        .en    (w_en),
        .limit (w_limit),
        .tc    (w_tc)
    );

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cpol_l  <= 1'b0;
            r_nbits_l <= '0;
            r_bitcnt  <= '0;
            r_la_m1   <= '0;
            r_li_m1   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_lead    <= 1'b0;
            r_trail   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_lead  <= 1'b0;
            r_trail <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_sck <= cpol;
                    if (start && (nbits != '0)) begin
                        r_cpol_l  <= cpol;
                        r_nbits_l <= nbits;
                        r_la_m1   <= w_la - c_DIV_ONE;
                        r_li_m1   <= w_li - c_DIV_ONE;
                        r_bitcnt  <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_ST_IDLE_PH;
                    end
                end
                c_ST_IDLE_PH: begin
                    if (w_tc) begin
                        r_sck   <= ~r_cpol_l;
                        r_lead  <= 1'b1;
                        r_state <= c_ST_ACT_PH;
                    end
                end
                c_ST_ACT_PH: begin
                    if (w_tc) begin
                        r_sck    <= r_cpol_l;
                        r_trail  <= 1'b1;
                        r_bitcnt <= r_bitcnt + c_CNT_ONE;
                        // Compare before incrementing so a full-range burst never wraps.
                        if (r_bitcnt == (r_nbits_l - c_CNT_ONE)) begin
                            r_state <= c_ST_HOLD;
                        end else begin
                            r_state <= c_ST_IDLE_PH;
                        end
                    end
                end
                c_ST_HOLD: begin
                    r_sck <= r_cpol_l;
                    if (w_tc) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sck       = r_sck;
    assign lead_stb  = r_lead;
    assign trail_stb = r_trail;

endmodule
`default_nettype wire

// File: tb/tb_spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sck_gen
// Brief    : Scoreboard bench for spi_sck_gen against a timeline reference model
// Revision : 1.0
// ============================================================================
module tb_spi_sck_gen;

    localparam int DIV_W = 15;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] div;
    logic             cpol;
    logic [CNT_W-1:0] nbits;
    logic             start;
    logic             busy;
    logic             done;
    logic             sck;
    logic             lead_stb;
    logic             trail_stb;

    always #5 clk = ~clk;

    spi_sck_gen #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clkin     (clk),
        .reset     (rst),
        .div       (div),
        .cpol      (cpol),
        .nbits     (nbits),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .sck       (sck),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    // Expected pulse: kind 0 = lead, 1 = trail, 2 = done; cyc = observation cycle.
    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    typedef struct {
        int   t0;
        int   d;
        int   la;
        int   li;
        int   nb;
        logic cp;
    } win_t;

    ev_t  evq[$];
    win_t winq[$];

    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   free_at = 0;
    int   last_t0 = 0;
    logic rst_s   = 1'b1;
    logic cpol_s  = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_s  <= rst;
        cpol_s <= cpol;
    end

    task automatic chk(input string nm, input int c, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", nm, c, act, exp);
        end
    endtask

    task automatic check_ev(input logic sig, input int kind, input int c, input string nm);
        if (sig) begin
            tests++;
            if (evq.size() == 0) begin
                fails++;
                $display("FAIL %s at cycle %0d: pulse seen, none expected", nm, c);
            end else if (evq[0].kind != kind || evq[0].cyc != c) begin
                fails++;
                $display("FAIL %s at cycle %0d: pulse seen, expected kind %0d at cycle %0d",
                         nm, c, evq[0].kind, evq[0].cyc);
                if (evq[0].cyc == c) evq.delete(0);
            end else begin
                evq.delete(0);
            end
        end
    endtask

    // Monitor: strobes/done against the event queue, busy/sck against the burst timeline.
    always @(negedge clk) begin : mon
        int   c;
        int   o;
        int   k;
        int   q;
        int   tot;
        logic eb;
        logic es;
        c = cyc;
        while (evq.size() > 0 && evq[0].cyc < c) begin
            tests++;
            fails++;
            $display("FAIL missed_event kind %0d: due at cycle %0d, not seen by cycle %0d",
                     evq[0].kind, evq[0].cyc, c);
            evq.delete(0);
        end
        check_ev(lead_stb,  0, c, "lead_stb");
        check_ev(trail_stb, 1, c, "trail_stb");
        check_ev(done,      2, c, "done");
        while (winq.size() > 0 &&
               c > winq[0].t0 + winq[0].nb * winq[0].d + winq[0].li) winq.delete(0);
        eb = 1'b0;
        es = cpol_s;
        if (rst_s) begin
            es = 1'b0;
        end else if (winq.size() > 0 && c >= winq[0].t0) begin
            o   = c - winq[0].t0;
            tot = winq[0].nb * winq[0].d + winq[0].li;
            eb  = (o < tot);
            es  = winq[0].cp;
            if (o >= winq[0].li) begin
                k = (o - winq[0].li) / winq[0].d;
                q = (o - winq[0].li) % winq[0].d;
                if (k < winq[0].nb && q < winq[0].la) es = ~winq[0].cp;
            end
        end
        chk("busy", c, busy, eb);
        chk("sck",  c, sck,  es);
    end

    // Drive one cycle of inputs and let the model decide whether the next edge accepts a burst.
    task automatic step(input logic s, input int d, input logic cp, input int nb, input logic rs);
        int   e;
        int   de;
        win_t w;
        @(negedge clk);
        #1;
        start = s;
        div   = DIV_W'(d);
        cpol  = cp;
        nbits = CNT_W'(nb);
        rst   = rs;
        e     = cyc + 1;
        if (rs) begin
            evq.delete();
            winq.delete();
            free_at = e + 1;
        end else if (s && nb != 0 && e >= free_at) begin
            de   = (d < 2) ? 2 : d;
            w.t0 = e;
            w.d  = de;
            w.la = de / 2;
            w.li = de - de / 2;
            w.nb = nb;
            w.cp = cp;
            winq.push_back(w);
            for (int i = 0; i < nb; i++) begin
                evq.push_back('{e + w.li + i * de, 0});
                evq.push_back('{e + w.li + w.la + i * de, 1});
            end
            evq.push_back('{e + nb * de + w.li, 2});
            free_at = e + nb * de + w.li + 1;
            last_t0 = e;
        end
    endtask

    task automatic burst(input int d, input logic cp, input int nb);
        step(1'b1, d, cp, nb, 1'b0);
        step(1'b0, d, cp, nb, 1'b0);
    endtask

    task automatic wait_idle(input int d, input logic cp, input int nb);
        int n;
        n = 0;
        while (cyc < free_at && n < 5000) begin
            step(1'b0, d, cp, nb, 1'b0);
            n++;
        end
        if (cyc < free_at) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: cycle %0d, model idle from %0d", cyc, free_at);
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d;
        int nb;
        int hold;
        int gap;
        int target;
        logic cp;
        rst   = 1'b1;
        start = 1'b0;
        div   = DIV_W'(4);
        cpol  = 1'b0;
        nbits = CNT_W'(1);
        repeat (3) step(1'b0, 4, 1'b0, 1, 1'b1);
        repeat (2) step(1'b0, 4, 1'b0, 1, 1'b0);

        burst(4, 1'b0, 1);
        wait_idle(4, 1'b0, 1);
        burst(3, 1'b1, 3);
        wait_idle(3, 1'b1, 3);
        repeat (3) step(1'b0, 3, 1'b1, 3, 1'b0);

        burst(0, 1'b0, 4);
        wait_idle(0, 1'b0, 4);
        burst(1, 1'b1, 2);
        wait_idle(1, 1'b1, 2);
        burst(2, 1'b0, 3);
        wait_idle(2, 1'b0, 3);

        repeat (3) step(1'b1, 5, 1'b1, 0, 1'b0);
        repeat (4) step(1'b0, 5, 1'b1, 0, 1'b0);

        repeat (30) step(1'b1, 3, 1'b0, 2, 1'b0);
        wait_idle(3, 1'b0, 2);

        step(1'b1, 6, 1'b0, 3, 1'b0);
        repeat (5) step(1'b0, 6, 1'b0, 3, 1'b0);
        repeat (4) step(1'b1, 2, 1'b1, 3, 1'b0);
        wait_idle(2, 1'b1, 3);
        burst(2, 1'b1, 3);
        wait_idle(2, 1'b1, 3);

        step(1'b1, 4, 1'b0, 5, 1'b0);
        target = last_t0 + 2 + 4;
        while (cyc + 1 < target) step(1'b0, 4, 1'b0, 5, 1'b0);
        step(1'b0, 4, 1'b0, 5, 1'b1);
        repeat (2) step(1'b0, 4, 1'b0, 5, 1'b0);
        burst(5, 1'b1, 2);
        wait_idle(5, 1'b1, 2);

        burst(2, 1'b0, 63);
        wait_idle(2, 1'b0, 63);

        for (int it = 0; it < 25; it++) begin
            d    = int'($urandom_range(0, 9));
            cp   = 1'($urandom_range(0, 1));
            nb   = int'($urandom_range(0, 6));
            hold = int'($urandom_range(1, 12));
            gap  = int'($urandom_range(0, 10));
            repeat (hold) step(1'b1, d, cp, nb, 1'b0);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 6)), 1'b0);
            end
        end
        wait_idle(2, 1'b0, 1);
        repeat (3) step(1'b0, 2, 1'b0, 1, 1'b0);

        tests++;
        if (evq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected pulses never seen, required 0", evq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
